// File: rtl/fetch_queue.sv
// Instruction fetch queue: requests two sequential words per handshake and
// buffers {pc, inst} pairs in a circular buffer for an in-order consumer.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   InstMem_Read    fetch request for the word pair at inst_address
//   inst_address    byte address of the first word (word aligned)
//   InstMem_Ready   same-cycle acknowledge; inst1_in/inst2_in valid when high
//   inst1_in        word at inst_address
//   inst2_in        word at inst_address + 4
//   redirect        flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] ignored)
//   deq_count       entries taken by the consumer this cycle (3 acts as 2)
//   valid1, valid2  head / head+1 entry valid
//   inst1_out, inst2_out  instruction at head / head+1
//   pc1_out, pc2_out      PC of head / head+1
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        InstMem_Read,
   output logic [31:0] inst_address,
   input  logic        InstMem_Ready,
   input  logic [31:0] inst1_in,
   input  logic [31:0] inst2_in,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [1:0]  deq_count,
   output logic        valid1,
   output logic        valid2,
   output logic [31:0] inst1_out,
   output logic [31:0] inst2_out,
   output logic [31:0] pc1_out,
   output logic [31:0] pc2_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_TWO   = CW'(2);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_inst_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_fetch_pc;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic [CW-1:0] w_free;
   logic          w_space;
   logic          w_read;
   logic          w_enq;
   logic [1:0]    w_deq_req;
   logic [CW-1:0] w_deq_eff;
   logic [CW-1:0] w_enq_amt;
   logic [CW-1:0] w_count_nxt;
   logic [AW-1:0] w_head1;
   logic [AW-1:0] w_tail1;
   logic [31:0]   w_fetch_pc4;
   logic [31:0]   w_fetch_pc8;
   logic [31:0]   w_redir_pc;
   logic          w_unused;

   // Free space uses the registered count only; a same-cycle dequeue
   // does not open room for a fetch until the following cycle.
   assign w_free  = C_DEPTH - r_count;
   assign w_space = (w_free >= C_TWO);

   assign w_read = !rst && !redirect && w_space;
   assign w_enq  = w_read && InstMem_Ready;

   // deq_count of 2 or 3 both mean "take two".
   assign w_deq_req = deq_count[1] ? 2'd2 : deq_count;

   // Never dequeue more than is held, so an odd count drains safely.
   always_comb begin
      w_deq_eff = CW'(w_deq_req);
      if (r_count < CW'(w_deq_req)) begin
         w_deq_eff = r_count;
      end
   end

   assign w_enq_amt   = w_enq ? C_TWO : '0;
   assign w_count_nxt = r_count + w_enq_amt - w_deq_eff;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign w_head1 = r_head + AW'(1);
   assign w_tail1 = r_tail + AW'(1);

   assign w_fetch_pc4 = r_fetch_pc + 32'd4;
   assign w_fetch_pc8 = r_fetch_pc + 32'd8;
   assign w_redir_pc  = {redirect_pc[31:2], 2'b00};

   assign w_unused = ^redirect_pc[1:0];

   // ------------------------------------------------------------------
   // Pointer, count and fetch PC registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_fetch_pc <= w_redir_pc;
      end else begin
         r_head  <= r_head + AW'(w_deq_eff);
         r_count <= w_count_nxt;
         if (w_enq) begin
            r_tail     <= r_tail + AW'(2);
            r_fetch_pc <= w_fetch_pc8;
         end
      end
   end

   // ------------------------------------------------------------------
   // Entry storage (no reset; validity is tracked by r_count)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_pc_mem[r_tail]    <= r_fetch_pc;
         r_inst_mem[r_tail]  <= inst1_in;
         r_pc_mem[w_tail1]   <= w_fetch_pc4;
         r_inst_mem[w_tail1] <= inst2_in;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign InstMem_Read = w_read;
   assign inst_address = r_fetch_pc;

   // Gated by rst so a mid-operation reset hides entries immediately.
   assign valid1 = !rst && (r_count != '0);
   assign valid2 = !rst && (r_count >= C_TWO);

   assign inst1_out = r_inst_mem[r_head];
   assign inst2_out = r_inst_mem[w_head1];
   assign pc1_out   = r_pc_mem[r_head];
   assign pc2_out   = r_pc_mem[w_head1];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, stall, odd drain, simultaneous
// enqueue/dequeue, redirect and mid-operation reset.
module tb_fetch_queue;

   localparam logic [31:0] K = 32'hA5A5_0F0F;

   logic        clk = 1'b0;
   logic        rst;
   logic        InstMem_Read;
   logic [31:0] inst_address;
   logic        InstMem_Ready;
   logic [31:0] inst1_in;
   logic [31:0] inst2_in;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [1:0]  deq_count;
   logic        valid1;
   logic        valid2;
   logic [31:0] inst1_out;
   logic [31:0] inst2_out;
   logic [31:0] pc1_out;
   logic [31:0] pc2_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory model: each word is its own address XOR a fixed key.
   assign inst1_in = inst_address ^ K;
   assign inst2_in = (inst_address + 32'd4) ^ K;

   fetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .InstMem_Read (InstMem_Read),
      .inst_address (inst_address),
      .InstMem_Ready(InstMem_Ready),
      .inst1_in     (inst1_in),
      .inst2_in     (inst2_in),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .deq_count    (deq_count),
      .valid1       (valid1),
      .valid2       (valid2),
      .inst1_out    (inst1_out),
      .inst2_out    (inst2_out),
      .pc1_out      (pc1_out),
      .pc2_out      (pc2_out)
   );

   task automatic chk32(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic head(input string tag, input logic v1, input logic v2,
                       input logic [31:0] p1, input logic [31:0] p2);
      chk1({tag, ".valid1"}, valid1, v1);
      chk1({tag, ".valid2"}, valid2, v2);
      if (v1) begin
         chk32({tag, ".pc1"}, pc1_out, p1);
         chk32({tag, ".inst1"}, inst1_out, p1 ^ K);
      end
      if (v2) begin
         chk32({tag, ".pc2"}, pc2_out, p2);
         chk32({tag, ".inst2"}, inst2_out, p2 ^ K);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input logic r, input logic rdy, input logic [1:0] dq,
                      input logic rd, input logic [31:0] rpc);
      rst           = r;
      InstMem_Ready = rdy;
      deq_count     = dq;
      redirect      = rd;
      redirect_pc   = rpc;
      #1;
   endtask

   initial begin
      // Reset
      set(1, 1, 0, 0, 0);
      chk1("rst_pre.read", InstMem_Read, 1'b0);
      tick();
      chk1("rst.read", InstMem_Read, 1'b0);
      head("rst", 0, 0, 0, 0);

      // Fill with a 3-cycle stall at 0x10
      set(0, 1, 0, 0, 0);
      chk1("fill0.read", InstMem_Read, 1'b1);
      chk32("fill0.addr", inst_address, 32'h0);
      head("fill0", 0, 0, 0, 0);
      tick();
      set(0, 1, 0, 0, 0);
      head("fill1", 1, 1, 32'h0, 32'h4);
      chk32("fill1.addr", inst_address, 32'h8);
      tick();
      for (int i = 0; i < 3; i++) begin
         set(0, 0, 0, 0, 0);
         chk1("stall.read", InstMem_Read, 1'b1);
         chk32("stall.addr", inst_address, 32'h10);
         head("stall", 1, 1, 32'h0, 32'h4);
         tick();
      end
      set(0, 1, 0, 0, 0);
      chk32("resume.addr", inst_address, 32'h10);
      tick();
      chk32("fill3.addr", inst_address, 32'h18);
      tick();
      chk1("full.read", InstMem_Read, 1'b0);
      chk32("full.addr", inst_address, 32'h20);
      head("full", 1, 1, 32'h0, 32'h4);

      // Odd drain with fetch blocked
      for (int i = 0; i < 8; i++) begin
         set(0, 0, 1, 0, 0);
         head("drain", 1, (i < 7), 32'(4 * i), 32'(4 * i + 4));
         chk1("drain.read", InstMem_Read, (i >= 2));
         tick();
      end
      set(0, 0, 0, 0, 0);
      head("empty", 0, 0, 0, 0);
      chk32("empty.addr", inst_address, 32'h20);

      // Refill to 6, then simultaneous enqueue and dequeue
      set(0, 1, 0, 0, 0);
      tick();
      tick();
      tick();
      set(0, 1, 2, 0, 0);
      head("six", 1, 1, 32'h20, 32'h24);
      chk1("six.read", InstMem_Read, 1'b1);
      tick();
      set(0, 0, 3, 0, 0);
      head("simul", 1, 1, 32'h28, 32'h2c);
      tick();
      set(0, 1, 1, 0, 0);
      head("four", 1, 1, 32'h30, 32'h34);
      chk1("four.read", InstMem_Read, 1'b1);
      tick();
      set(0, 1, 0, 0, 0);
      head("five", 1, 1, 32'h34, 32'h38);
      tick();
      set(0, 1, 0, 0, 0);
      chk1("seven.read", InstMem_Read, 1'b0);
      chk32("seven.addr", inst_address, 32'h50);
      head("seven", 1, 1, 32'h34, 32'h38);
      set(0, 1, 2, 0, 0);
      tick();

      // Redirect with 5 held and a same-cycle handshake
      set(0, 1, 0, 1, 32'h103);
      chk1("redir.read", InstMem_Read, 1'b0);
      head("redir_pre", 1, 1, 32'h3c, 32'h40);
      tick();
      set(0, 0, 0, 0, 0);
      head("redir", 0, 0, 0, 0);
      chk32("redir.addr", inst_address, 32'h100);
      chk1("redir.read2", InstMem_Read, 1'b1);
      tick();
      set(0, 1, 0, 0, 0);
      head("redir_wait", 0, 0, 0, 0);
      tick();
      set(0, 0, 1, 0, 0);
      head("redir_first", 1, 1, 32'h100, 32'h104);
      chk32("redir_first.addr", inst_address, 32'h108);
      tick();
      set(0, 0, 2, 0, 0);
      head("odd1", 1, 0, 32'h104, 0);
      tick();
      set(0, 0, 3, 0, 0);
      head("odd_empty", 0, 0, 0, 0);
      tick();
      set(0, 1, 0, 0, 0);
      head("deq_empty", 0, 0, 0, 0);
      chk32("deq_empty.addr", inst_address, 32'h108);
      tick();
      set(0, 1, 0, 0, 0);
      head("refill", 1, 1, 32'h108, 32'h10c);
      tick();

      // Reset mid-operation with count 4 and a fetch in flight
      set(1, 1, 0, 0, 0);
      chk1("mrst.read", InstMem_Read, 1'b0);
      head("mrst", 0, 0, 0, 0);
      tick();
      set(0, 0, 0, 0, 0);
      head("mrst_post", 0, 0, 0, 0);
      chk32("mrst.addr", inst_address, 32'h0);
      chk1("mrst.read2", InstMem_Read, 1'b1);
      tick();
      set(0, 1, 0, 0, 0);
      head("mrst_idle", 0, 0, 0, 0);
      tick();
      set(0, 0, 0, 0, 0);
      head("mrst_fetch", 1, 1, 32'h0, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
